// File: rtl/goldschmidt_seq.sv
// Valid/ready sequencer for the Goldschmidt divide datapath: holds operands,
// steps the mode/stage/rem controls through scaling, refinement and remainder.
module goldschmidt_seq #(
  parameter int WIDTH = 30,
  parameter int ITER  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] numerator,
  input  logic [WIDTH-1:0] denominator,
  output logic [WIDTH-1:0] dp_numerator,
  output logic [WIDTH-1:0] dp_denominator,
  output logic             dp_mode,
  output logic             dp_stage,
  output logic             dp_rem,
  input  logic [WIDTH-1:0] dp_quotient,
  input  logic [WIDTH-1:0] dp_remainder,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int IT_W = $clog2(ITER + 1);
  localparam logic [IT_W-1:0] IT_LAST = IT_W'(ITER);
  localparam logic [IT_W-1:0] IT_ONE  = IT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT0 = 3'd1,
    S_INIT1 = 3'd2,
    S_ITER  = 3'd3,
    S_REM   = 3'd4,
    S_CAPT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t           state_reg, state_next;
  logic [IT_W-1:0]  it_reg, it_next;
  logic [IT_W-1:0]  it_inc;
  logic             phase_reg, phase_next;
  logic [WIDTH-1:0] num_reg, num_next;
  logic [WIDTH-1:0] den_reg, den_next;
  logic [WIDTH-1:0] quo_reg, quo_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic             dbz_reg, dbz_next;
  logic             den_zero;

  assign den_zero = (denominator == '0);
  assign it_inc   = it_reg + IT_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      it_reg    <= '0;
      phase_reg <= 1'b0;
      num_reg   <= '0;
      den_reg   <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      it_reg    <= it_next;
      phase_reg <= phase_next;
      num_reg   <= num_next;
      den_reg   <= den_next;
      quo_reg   <= quo_next;
      rem_reg   <= rem_next;
      dbz_reg   <= dbz_next;
    end
  end

  // Flush overrides every transition, including an acceptance in IDLE.
  always_comb begin
    state_next = state_reg;
    it_next    = it_reg;
    phase_next = phase_reg;
    num_next   = num_reg;
    den_next   = den_reg;
    quo_next   = quo_reg;
    rem_next   = rem_reg;
    dbz_next   = dbz_reg;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            num_next = numerator;
            den_next = denominator;
            if (den_zero) begin
              quo_next   = '1;
              rem_next   = numerator;
              dbz_next   = 1'b1;
              state_next = S_DONE;
            end else begin
              state_next = S_INIT0;
            end
          end
        end
        S_INIT0: state_next = S_INIT1;
        S_INIT1: begin
          it_next    = '0;
          phase_next = 1'b0;
          state_next = S_ITER;
        end
        S_ITER: begin
          phase_next = ~phase_reg;
          if (phase_reg) begin
            it_next = it_inc;
            if (it_inc == IT_LAST) begin
              state_next = S_REM;
            end
          end
        end
        S_REM:  state_next = S_CAPT;
        S_CAPT: begin
          quo_next   = dp_quotient;
          rem_next   = dp_remainder;
          dbz_next   = 1'b0;
          state_next = S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Datapath controls are pure decodes of the state and stage phase.
  always_comb begin
    dp_mode  = 1'b0;
    dp_stage = 1'b0;
    dp_rem   = 1'b0;
    case (state_reg)
      S_INIT1: dp_stage = 1'b1;
      S_ITER: begin
        dp_mode  = 1'b1;
        dp_stage = phase_reg;
      end
      S_REM: begin
        dp_stage = 1'b1;
        dp_rem   = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_ready       = (state_reg == S_IDLE);
  assign busy           = (state_reg != S_IDLE);
  assign out_valid      = (state_reg == S_DONE);
  assign dp_numerator   = num_reg;
  assign dp_denominator = den_reg;
  assign quotient       = quo_reg;
  assign remainder      = rem_reg;
  assign div_by_zero    = dbz_reg;

endmodule

// File: tb/tb_goldschmidt_seq.sv
// Directed bench for goldschmidt_seq (ITER=4) with a counting stub datapath.
module tb_goldschmidt_seq;

  localparam int W = 30;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] numerator = '0;
  logic [W-1:0] denominator = '0;
  logic [W-1:0] dp_numerator, dp_denominator;
  logic         dp_mode, dp_stage, dp_rem;
  logic [W-1:0] dp_quotient, dp_remainder;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient, remainder;
  logic         div_by_zero;
  logic         busy;

  logic [W-1:0] cyc = '0;
  int checks = 0;
  int passes = 0;

  goldschmidt_seq #(.WIDTH(W), .ITER(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .numerator(numerator), .denominator(denominator),
    .dp_numerator(dp_numerator), .dp_denominator(dp_denominator),
    .dp_mode(dp_mode), .dp_stage(dp_stage), .dp_rem(dp_rem),
    .dp_quotient(dp_quotient), .dp_remainder(dp_remainder),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stub datapath: outputs move every cycle so capture timing is visible.
  always @(posedge clk) cyc <= cyc + 30'd1;
  assign dp_quotient  = 30'h0100000 + cyc;
  assign dp_remainder = 30'h2A00000 ^ cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
    check({tag, "_quotient"}, 64'(quotient), 64'd0);
    check({tag, "_remainder"}, 64'(remainder), 64'd0);
    check({tag, "_dp_num"}, 64'(dp_numerator), 64'd0);
    check({tag, "_dp_den"}, 64'(dp_denominator), 64'd0);
    check({tag, "_ctl"}, 64'({dp_mode, dp_stage, dp_rem}), 64'd0);
  endtask

  // Drive one operand pair and take the acceptance edge; returns in cycle 1.
  task automatic accept(input logic [W-1:0] n, input logic [W-1:0] d);
    numerator   = n;
    denominator = d;
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
  endtask

  logic [2:0]   exp_ctl [12];
  logic [W-1:0] q_cap, r_cap;
  int           lat;
  int           ov_seen;

  initial begin
    exp_ctl = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b100, 3'b110,
                3'b100, 3'b110, 3'b100, 3'b110, 3'b011, 3'b000};
    q_cap = '0;
    r_cap = '0;

    // Reset held two cycles.
    tick();
    tick();
    reset = 1'b0;
    check_reset_values("reset");
    $display("txn reset: outputs checked after 2-cycle reset");

    // Normal transaction: control sequence cycles 1..12, result in cycle 13.
    accept(30'h1000000, 30'h0C00000);
    check("norm_dp_num", 64'(dp_numerator), 64'h1000000);
    check("norm_dp_den", 64'(dp_denominator), 64'h0C00000);
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("norm_ctl_c%0d", c), 64'({dp_mode, dp_stage, dp_rem}), 64'(exp_ctl[c-1]));
      check($sformatf("norm_ov_c%0d", c), 64'({out_valid, in_ready, busy}), 64'b001);
      if (c == 12) begin
        q_cap = dp_quotient;
        r_cap = dp_remainder;
      end
      tick();
    end
    check("norm_out_valid", 64'(out_valid), 64'd1);
    check("norm_in_ready", 64'(in_ready), 64'd0);
    check("norm_quotient", 64'(quotient), 64'(q_cap));
    check("norm_remainder", 64'(remainder), 64'(r_cap));
    check("norm_dbz", 64'(div_by_zero), 64'd0);
    check("norm_ctl_done", 64'({dp_mode, dp_stage, dp_rem}), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("norm_release", 64'({out_valid, in_ready, busy}), 64'b010);
    $display("txn normal: N=1000000 D=0C00000 q=%h r=%h", quotient, remainder);

    // Divide-by-zero bypass.
    accept(30'h0ABCDEF, 30'h0);
    check("dbz_out_valid", 64'(out_valid), 64'd1);
    check("dbz_quotient", 64'(quotient), 64'h3FFFFFFF);
    check("dbz_remainder", 64'(remainder), 64'h0ABCDEF);
    check("dbz_flag", 64'(div_by_zero), 64'd1);
    check("dbz_ctl", 64'({dp_mode, dp_stage, dp_rem}), 64'd0);
    check("dbz_dp_num", 64'(dp_numerator), 64'h0ABCDEF);
    check("dbz_dp_den", 64'(dp_denominator), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("dbz_release", 64'({out_valid, in_ready}), 64'b01);
    $display("txn div_by_zero: N=0ABCDEF D=0 q=%h r=%h", quotient, remainder);

    // Backpressure: result holds while the stub keeps changing.
    accept(30'h0123456, 30'h0000789);
    for (int c = 1; c <= 12; c++) begin
      if (c == 12) begin
        q_cap = dp_quotient;
        r_cap = dp_remainder;
      end
      tick();
    end
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_dbz_cleared", 64'(div_by_zero), 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp_hold_q%0d", k), 64'(quotient), 64'(q_cap));
      check($sformatf("bp_hold_r%0d", k), 64'(remainder), 64'(r_cap));
      check($sformatf("bp_hold_hs%0d", k), 64'({out_valid, in_ready}), 64'b10);
    end
    check("bp_dp_num_held", 64'(dp_numerator), 64'h0123456);
    out_ready = 1'b1;
    check("bp_in_ready_same_cycle", 64'(in_ready), 64'd0);
    tick();
    out_ready = 1'b0;
    check("bp_in_ready_after", 64'({out_valid, in_ready}), 64'b01);
    $display("txn backpressure: 5 stall cycles, q=%h r=%h", quotient, remainder);

    // Flush in the third ITER cycle.
    accept(30'h0111111, 30'h0000333);
    for (int c = 1; c < 5; c++) tick();
    check("flush_at_iter3_ctl", 64'({dp_mode, dp_stage, dp_rem}), 64'b100);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_state", 64'({out_valid, in_ready, busy}), 64'b010);
    check("flush_ctl", 64'({dp_mode, dp_stage, dp_rem}), 64'd0);
    ov_seen = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (out_valid) ov_seen++;
    end
    check("flush_no_out_valid", 64'(ov_seen), 64'd0);
    // Flush coincident with acceptance must not latch the operands.
    numerator   = 30'h2222222;
    denominator = 30'h0000444;
    in_valid    = 1'b1;
    flush       = 1'b1;
    tick();
    in_valid    = 1'b0;
    flush       = 1'b0;
    check("flush_accept_idle", 64'({in_ready, busy}), 64'b10);
    check("flush_accept_dp_num", 64'(dp_numerator), 64'h0111111);
    // Subsequent transaction completes with normal latency.
    accept(30'h0345678, 30'h0000123);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("flush_next_latency", 64'(lat), 64'd13);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("txn flush: aborted in ITER, next latency=%0d", lat);

    // Reset during REM.
    accept(30'h0456789, 30'h0000055);
    for (int c = 1; c < 11; c++) tick();
    check("mrst_in_rem", 64'({dp_mode, dp_stage, dp_rem}), 64'b011);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("mrst");
    ov_seen = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (out_valid) ov_seen++;
    end
    check("mrst_no_stale_valid", 64'(ov_seen), 64'd0);
    $display("txn mid_reset: reset in REM, outputs checked");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
